cell_move_encoder: RTL and testbench
====================================

// Module: cell_move_encoder
// PURPOSE
//  Converts a 9-bit cell-request bus into a (row, col) move with a valid/ready handshake.
//  The request bus comes from board push-buttons, one per cell. This is the inverse of the
//  board's row/col-to-one-hot cell decoder.
//  It synchronises and debounces the buttons, rejects multi-press and occupied-cell requests,
//  and issues exactly one move per press.
//  Sits between the button pads and the game controller. The controller drives the decoder
//  with set = move_valid & move_ready.
// PARAMETERS
//  DB_CYCLES  16  consecutive stable cycles required for press and for release (>=2)
// PORTS
//  clk         in   1  single clock, all state on rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  req         in   9  raw async cell buttons, bit i = cell i, active-high
//  occupied    in   9  board occupancy mask from game controller, bit i = cell i taken
//  clear       in   1  sync abort: drop any pending move, return to IDLE
//  move_ready  in   1  controller accepts move this cycle
//  move_valid  out  1  row/col hold a legal move
//  row         out  2  row code of move (00 = none)
//  col         out  2  col code of move (00 = none)
//  err_multi   out  1  1-cycle pulse: stable press had popcount != 1
//  err_occ     out  1  1-cycle pulse: stable single press hit an occupied cell
//  busy        out  1  FSM not in IDLE
// BEHAVIOUR
//  Cell encoding (must match the decoder exactly): for cell i, row = 3 - (i mod 3), col = 3 - (i div 3).
//   Resulting codes: i=8 -> row 01/col 01, i=4 -> 10/10, i=0 -> 11/11. Code 00 is never issued.
//  Reset values:
//   - All outputs 0; row = col = 00; FSM in IDLE; sync flops and counter 0.
//   - Reset is asynchronous and may hit mid-operation; any pending move is lost.
//  req passes a 2-flop synchroniser (sreq). Nothing uses raw req.
//  FSM:
//   IDLE:     sreq != 0 -> snap <= sreq, cnt <= 0, go DEBOUNCE.
//   DEBOUNCE: sreq != snap -> IDLE (no error). Otherwise cnt++.
//             When cnt == DB_CYCLES-1, evaluate snap:
//               popcount(snap) != 1      -> err_multi pulse, go RELEASE
//               (snap & occupied) != 0   -> err_occ pulse, go RELEASE
//               otherwise                -> load row/col, go ISSUE
//             occupied is sampled in the evaluation cycle only.
//   ISSUE:    move_valid = 1. row/col are stable until the transfer.
//             On move_valid & move_ready: next cycle move_valid = 0, row/col = 00, go RELEASE.
//   RELEASE:  cnt counts consecutive cycles with sreq == 0; any nonzero sreq resets cnt.
//             When cnt == DB_CYCLES-1 -> IDLE. Holding a button never issues a second move.
//  Latency: a clean press gives move_valid high 2 (sync) + DB_CYCLES + 1 cycles after req rises.
//  clear: from any state, next state is IDLE; move_valid, row, col -> 0 next cycle.
//   If clear and move_valid & move_ready coincide, the transfer counts as done and the
//   state still goes to IDLE, not RELEASE.
//   clear has priority over error pulses generated in the same cycle (no pulse issued).
//  Counter width = $clog2(DB_CYCLES). The counter saturates and never wraps.
//  busy = (state != IDLE), registered from state.
// STRUCTURE
//  Shared package/header (ttt_defs): cell-index-to-row/col encoding function, ROW/COL code
//   constants, NO_CELL = 2'b00, FSM state encodings.
//  One sub-module: cell_onehot_enc (combinational, 9-bit one-hot -> row, col, onehot_ok).
//   Reused by the AI-move path.
//  Top: synchroniser, counter, FSM, output registers.
// TESTING  (DB_CYCLES = 4 for sims)
//  1. req = 9'h100, occupied = 0, ready = 1 -> one move_valid with row = 01, col = 01;
//     then release.
//  2. Press each cell i = 0..8 in turn -> row/col match the encoding. Looping the outputs
//     through the decoder with set = 1 reproduces 1 << i.
//  3. req = 9'h011 -> err_multi pulse of exactly 1 cycle, no move_valid.
//     req = 9'h010 with occupied = 9'h010 -> err_occ pulse, no move.
//  4. Bounce: req toggles every 2 cycles for 20 cycles, then holds 9'h004 -> exactly one move
//     row = 01, col = 11. Holding it 100 cycles -> no second move.
//  5. ready = 0 for 10 cycles in ISSUE -> move_valid and row/col stable.
//     Then clear = 1 and ready = 1 together -> IDLE next cycle, move_valid = 0.
//  6. rst_n low mid-DEBOUNCE and mid-ISSUE -> all outputs 0 immediately (async).
//     After reset release, a new press works.

Source files
------------

// File: rtl/cell_move_encoder_pkg.sv
// ----------------------------------------------------------------------------
// cell_move_encoder_pkg
//  Shared definitions for the board cell encode/decode path:
//   - row/col code constants (NO_CELL = 2'b00 is never issued as a move)
//   - cell index -> row/col encoding functions (must match the board decoder)
//   - 9-bit popcount helper
//   - encoder FSM state encoding
// ----------------------------------------------------------------------------
package cell_move_encoder_pkg;

   localparam int         NUM_CELLS = 9;
   localparam logic [1:0] NO_CELL   = 2'b00;
   localparam logic [1:0] CODE_LO   = 2'b01;
   localparam logic [1:0] CODE_MID  = 2'b10;
   localparam logic [1:0] CODE_HI   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_ISSUE    = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   // Cell i sits at row 3 - (i mod 3), col 3 - (i div 3): cell 8 -> 01/01,
   // cell 4 -> 10/10, cell 0 -> 11/11.
   function automatic logic [1:0] cell_row(input int idx);
      return 2'(3 - (idx % 3));
   endfunction

   function automatic logic [1:0] cell_col(input int idx);
      return 2'(3 - (idx / 3));
   endfunction

   function automatic logic [3:0] popcount9(input logic [NUM_CELLS-1:0] cells);
      logic [3:0] sum;
      sum = 4'd0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         sum = sum + {3'b000, cells[i]};
      end
      return sum;
   endfunction

endpackage

// File: rtl/cell_move_encoder_if.sv
// ----------------------------------------------------------------------------
// cell_move_if
//  Move handshake between the cell encoder (master) and the game controller
//  (slave).
//   move_valid  master->slave  row/col hold a legal move
//   move_ready  slave->master  controller accepts the move this cycle
//   row, col    master->slave  move coordinates, 2'b00 when no move
//  Handshake: a move transfers on a rising clk edge where move_valid and
//  move_ready are both high; while move_valid is high without move_ready,
//  row/col stay unchanged. move_ready may be asserted at any time.
// ----------------------------------------------------------------------------
interface cell_move_if;
   logic       move_valid;
   logic       move_ready;
   logic [1:0] row;
   logic [1:0] col;

   modport master (output move_valid, output row, output col, input move_ready);
   modport slave  (input move_valid, input row, input col, output move_ready);
endinterface

// File: rtl/cell_move_encoder_onehot_enc.sv
// ----------------------------------------------------------------------------
// cell_onehot_enc
//  Combinational 9-bit one-hot cell mask -> (row, col) encoder. Also used by
//  the AI-move path.
//   cells      in   9  cell mask, bit i = cell i
//   row, col   out  2  encoded coordinates; only meaningful when onehot_ok
//   onehot_ok  out  1  exactly one bit of cells is set
// ----------------------------------------------------------------------------
module cell_onehot_enc
   import cell_move_encoder_pkg::*;
(
   input  logic [NUM_CELLS-1:0] cells,
   output logic [1:0]           row,
   output logic [1:0]           col,
   output logic                 onehot_ok
);

   // OR-reduce the per-cell codes; with a single bit set this is the exact code.
   always_comb begin
      row = NO_CELL;
      col = NO_CELL;
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (cells[i]) begin
            row = row | cell_row(i);
            col = col | cell_col(i);
         end
      end
      onehot_ok = (popcount9(cells) == 4'd1);
   end

endmodule

// File: rtl/cell_move_encoder.sv
// ----------------------------------------------------------------------------
// cell_move_encoder
//  Turns the 9 board push-buttons into one (row, col) move per press.
//  Buttons are synchronised, debounced for DB_CYCLES stable cycles, checked
//  for single-press and free cell, and handed to the controller over a
//  valid/ready handshake. The button must then be released for DB_CYCLES
//  cycles before another press is accepted.
//   clk         in   1  clock
//   rst_n       in   1  asynchronous active-low reset
//   req         in   9  raw asynchronous buttons, bit i = cell i
//   occupied    in   9  board occupancy mask, sampled in the evaluation cycle
//   clear       in   1  synchronous abort back to IDLE
//   mv          master  move_valid / move_ready / row / col
//   err_multi   out  1  one-cycle pulse: stable press with popcount != 1
//   err_occ     out  1  one-cycle pulse: stable single press on a taken cell
//   busy        out  1  FSM not in IDLE
//   state_dbg   out  2  current FSM state
// ----------------------------------------------------------------------------
module cell_move_encoder
   import cell_move_encoder_pkg::*;
#(
   parameter int DB_CYCLES = 16
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_CELLS-1:0] req,
   input  logic [NUM_CELLS-1:0] occupied,
   input  logic                 clear,
   cell_move_if.master          mv,
   output logic                 err_multi,
   output logic                 err_occ,
   output logic                 busy,
   output logic [1:0]           state_dbg
);

   localparam int           CW       = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   state_t               state, state_nxt;
   logic [NUM_CELLS-1:0] sync1, sreq;
   logic [NUM_CELLS-1:0] snap, snap_nxt;
   logic [CW-1:0]        cnt, cnt_nxt, cnt_inc;
   logic                 valid_q, valid_nxt;
   logic [1:0]           row_q, row_nxt, col_q, col_nxt;
   logic                 multi_nxt, occ_nxt;
   logic [1:0]           enc_row, enc_col;
   logic                 enc_ok;

   cell_onehot_enc u_enc (
      .cells     (snap),
      .row       (enc_row),
      .col       (enc_col),
      .onehot_ok (enc_ok)
   );

   // Saturating increment: the counter never wraps.
   assign cnt_inc = (cnt == CNT_LAST) ? cnt : cnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= '0;
         sreq      <= '0;
         state     <= ST_IDLE;
         snap      <= '0;
         cnt       <= '0;
         valid_q   <= 1'b0;
         row_q     <= NO_CELL;
         col_q     <= NO_CELL;
         err_multi <= 1'b0;
         err_occ   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         sync1     <= req;
         sreq      <= sync1;
         state     <= state_nxt;
         snap      <= snap_nxt;
         cnt       <= cnt_nxt;
         valid_q   <= valid_nxt;
         row_q     <= row_nxt;
         col_q     <= col_nxt;
         err_multi <= multi_nxt;
         err_occ   <= occ_nxt;
         // Loaded from the next state so busy tracks the state register exactly.
         busy      <= (state_nxt != ST_IDLE);
      end
   end

   always_comb begin
      state_nxt = state;
      snap_nxt  = snap;
      cnt_nxt   = cnt;
      valid_nxt = valid_q;
      row_nxt   = row_q;
      col_nxt   = col_q;
      multi_nxt = 1'b0;
      occ_nxt   = 1'b0;

      case (state)
         ST_IDLE: begin
            if (sreq != '0) begin
               snap_nxt  = sreq;
               cnt_nxt   = '0;
               state_nxt = ST_DEBOUNCE;
            end
         end

         ST_DEBOUNCE: begin
            if (sreq != snap) begin
               // Bounce or changed press: silently start over.
               state_nxt = ST_IDLE;
            end else if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
               if (!enc_ok) begin
                  multi_nxt = 1'b1;
                  state_nxt = ST_RELEASE;
               end else if ((snap & occupied) != '0) begin
                  occ_nxt   = 1'b1;
                  state_nxt = ST_RELEASE;
               end else begin
                  valid_nxt = 1'b1;
                  row_nxt   = enc_row;
                  col_nxt   = enc_col;
                  state_nxt = ST_ISSUE;
               end
            end else begin
               cnt_nxt = cnt_inc;
            end
         end

         ST_ISSUE: begin
            if (valid_q && mv.move_ready) begin
               valid_nxt = 1'b0;
               row_nxt   = NO_CELL;
               col_nxt   = NO_CELL;
               cnt_nxt   = '0;
               state_nxt = ST_RELEASE;
            end
         end

         ST_RELEASE: begin
            // Needs DB_CYCLES consecutive all-released cycles; holding a
            // button keeps us here so it cannot issue a second move.
            if (sreq != '0) begin
               cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_IDLE;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end

         default: state_nxt = ST_IDLE;
      endcase

      // clear overrides everything, including error pulses from this cycle.
      if (clear) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
         valid_nxt = 1'b0;
         row_nxt   = NO_CELL;
         col_nxt   = NO_CELL;
         multi_nxt = 1'b0;
         occ_nxt   = 1'b0;
      end
   end

   assign mv.move_valid = valid_q;
   assign mv.row        = row_q;
   assign mv.col        = col_q;
   assign state_dbg     = state;

endmodule

// File: tb/tb_cell_move_encoder.sv
module tb_cell_move_encoder;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] req = '0;
  logic [8:0] occupied = '0;
  logic       clear = 1'b0;
  logic       err_multi, err_occ, busy;
  logic [1:0] state_dbg;

  cell_move_if mv ();

  cell_move_encoder #(.DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .occupied  (occupied),
    .clear     (clear),
    .mv        (mv),
    .err_multi (err_multi),
    .err_occ   (err_occ),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int xfers   = 0;
  int multi_cnt = 0;
  int occ_cnt   = 0;

  // Event monitors sample mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n && mv.move_valid && mv.move_ready) xfers++;
    if (rst_n && err_multi) multi_cnt++;
    if (rst_n && err_occ) occ_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    while (!mv.move_valid && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_idle(input int limit);
    int cyc;
    cyc = 0;
    while (busy && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_err(input bit occ_kind, input int limit);
    int cyc;
    cyc = 0;
    while (!(occ_kind ? err_occ : err_multi) && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         cyc;
    int         x0, m0, o0;
    int         idx;
    logic [8:0] one;
    logic [8:0] dec;
    logic [1:0] exp_row, exp_col;
    logic       stable;

    one = 9'b1;
    mv.move_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(mv.move_valid), 0);
    check("rst_row", 32'(mv.row), 0);
    check("rst_col", 32'(mv.col), 0);
    check("rst_err_multi", 32'(err_multi), 0);
    check("rst_err_occ", 32'(err_occ), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(state_dbg), 0);
    rst_n = 1'b1;
    tick();

    // 1. Single press of cell 8, latency 2 + DB + 1
    x0 = xfers;
    req = 9'h100;
    wait_valid(40, cyc);
    check("t1_latency", 32'(cyc), 32'(2 + DB + 1));
    check("t1_valid", 32'(mv.move_valid), 1);
    check("t1_row", 32'(mv.row), 32'(2'b01));
    check("t1_col", 32'(mv.col), 32'(2'b01));
    tick();
    check("t1_valid_drop", 32'(mv.move_valid), 0);
    check("t1_row_clr", 32'(mv.row), 0);
    check("t1_state_release", 32'(state_dbg), 3);
    req = '0;
    wait_idle(40);
    check("t1_idle", 32'(busy), 0);
    check("t1_xfers", 32'(xfers - x0), 1);

    // 2. Every cell; decode back through row/col -> one-hot
    for (int i = 0; i < 9; i++) begin
      x0 = xfers;
      req = one << i;
      exp_row = 2'(3 - (i % 3));
      exp_col = 2'(3 - (i / 3));
      wait_valid(40, cyc);
      check($sformatf("t2_valid_%0d", i), 32'(mv.move_valid), 1);
      check($sformatf("t2_row_%0d", i), 32'(mv.row), 32'(exp_row));
      check($sformatf("t2_col_%0d", i), 32'(mv.col), 32'(exp_col));
      idx = (3 - int'(mv.col)) * 3 + (3 - int'(mv.row));
      dec = (idx >= 0 && idx < 9) ? (one << idx) : 9'h000;
      check($sformatf("t2_decode_%0d", i), 32'(dec), 32'(one << i));
      tick();
      req = '0;
      wait_idle(40);
      check($sformatf("t2_xfers_%0d", i), 32'(xfers - x0), 1);
    end

    // 3a. Multi-press -> err_multi pulse, no move
    x0 = xfers;
    m0 = multi_cnt;
    req = 9'h011;
    wait_err(1'b0, 40);
    check("t3_multi_high", 32'(err_multi), 1);
    check("t3_multi_no_valid", 32'(mv.move_valid), 0);
    tick();
    check("t3_multi_low", 32'(err_multi), 0);
    req = '0;
    wait_idle(40);
    check("t3_multi_pulses", 32'(multi_cnt - m0), 1);
    check("t3_multi_xfers", 32'(xfers - x0), 0);

    // 3b. Occupied cell -> err_occ pulse, no move
    x0 = xfers;
    o0 = occ_cnt;
    occupied = 9'h010;
    req = 9'h010;
    wait_err(1'b1, 40);
    check("t3_occ_high", 32'(err_occ), 1);
    tick();
    check("t3_occ_low", 32'(err_occ), 0);
    req = '0;
    wait_idle(40);
    occupied = '0;
    check("t3_occ_pulses", 32'(occ_cnt - o0), 1);
    check("t3_occ_xfers", 32'(xfers - x0), 0);

    // 4. Bounce then hold cell 2: one move, none while held
    x0 = xfers;
    for (int k = 0; k < 10; k++) begin
      req = (k % 2 == 0) ? 9'h004 : 9'h000;
      tick();
      tick();
    end
    check("t4_bounce_no_move", 32'(xfers - x0), 0);
    req = 9'h004;
    wait_valid(40, cyc);
    check("t4_row", 32'(mv.row), 32'(2'b01));
    check("t4_col", 32'(mv.col), 32'(2'b11));
    tick();
    repeat (100) tick();
    check("t4_one_move", 32'(xfers - x0), 1);
    check("t4_held_busy", 32'(busy), 1);
    check("t4_held_no_valid", 32'(mv.move_valid), 0);
    req = '0;
    wait_idle(40);
    check("t4_idle", 32'(busy), 0);

    // 5. Back-pressure, then clear together with ready
    x0 = xfers;
    mv.move_ready = 1'b0;
    req = 9'h001;
    wait_valid(40, cyc);
    check("t5_row", 32'(mv.row), 32'(2'b11));
    check("t5_col", 32'(mv.col), 32'(2'b11));
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!mv.move_valid || mv.row !== 2'b11 || mv.col !== 2'b11) stable = 1'b0;
    end
    check("t5_stable", 32'(stable), 1);
    check("t5_state_issue", 32'(state_dbg), 2);
    clear = 1'b1;
    mv.move_ready = 1'b1;
    req = '0;
    tick();
    clear = 1'b0;
    check("t5_clr_valid", 32'(mv.move_valid), 0);
    check("t5_clr_row", 32'(mv.row), 0);
    check("t5_clr_col", 32'(mv.col), 0);
    check("t5_clr_state", 32'(state_dbg), 0);
    repeat (10) tick();
    check("t5_settled_idle", 32'(busy), 0);
    check("t5_xfers", 32'(xfers - x0), 1);

    // 6a. Async reset mid-DEBOUNCE
    req = 9'h080;
    repeat (4) tick();
    check("t6_in_debounce", 32'(state_dbg), 1);
    rst_n = 1'b0;
    #1;
    check("t6a_state", 32'(state_dbg), 0);
    check("t6a_busy", 32'(busy), 0);
    req = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 6b. Async reset mid-ISSUE
    mv.move_ready = 1'b0;
    req = 9'h080;
    wait_valid(40, cyc);
    check("t6b_row", 32'(mv.row), 32'(2'b10));
    check("t6b_col", 32'(mv.col), 32'(2'b01));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6b_valid", 32'(mv.move_valid), 0);
    check("t6b_row_rst", 32'(mv.row), 0);
    check("t6b_col_rst", 32'(mv.col), 0);
    check("t6b_busy", 32'(busy), 0);
    req = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    mv.move_ready = 1'b1;

    // 6c. Fresh press after reset
    x0 = xfers;
    req = 9'h020;
    wait_valid(40, cyc);
    check("t6c_latency", 32'(cyc), 32'(2 + DB + 1));
    check("t6c_row", 32'(mv.row), 32'(2'b01));
    check("t6c_col", 32'(mv.col), 32'(2'b10));
    tick();
    check("t6c_valid_drop", 32'(mv.move_valid), 0);
    req = '0;
    wait_idle(40);
    check("t6c_xfers", 32'(xfers - x0), 1);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
